// File: rtl/data_mem_responder.sv
// data_mem_responder: wait-state data memory answering MEM-stage loads and stores
module data_mem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [31:0]           Address,
  input  logic [DATA_WIDTH-1:0] Write_data,
  output logic [DATA_WIDTH-1:0] Read_data,
  output logic                  Stall,
  output logic                  Done,
  output logic                  Addr_error
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t                state_q;
  logic [3:0]            cnt_q;
  logic                  rd_q, wr_q;
  logic [31:0]           addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];
  logic                  req, err;
  logic [AW-1:0]         idx;
  assign req = MemRead | MemWrite;
  assign idx = addr_q[AW+1:2];
  assign err = (addr_q[1:0] != 2'b00) || (addr_q[31:2] >= 30'(DEPTH_WORDS)) || (rd_q && wr_q);
  // Value Read_data takes on completion: cleared by illegal accesses, untouched by stores
  assign rdata_d = err ? '0 : rd_q ? mem_q[idx] : rdata_q;
  assign Read_data  = (state_q == DONE) ? rdata_d : rdata_q;
  assign Stall      = (state_q == BUSY) || (state_q == IDLE && req);
  assign Done       = (state_q == DONE);
  assign Addr_error = (state_q == DONE) && err;
  // Access sequencer: latch the request, count wait states, complete for one cycle
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (req) begin
          rd_q    <= MemRead;
          wr_q    <= MemWrite;
          addr_q  <= Address;
          wdata_q <= Write_data;
          state_q <= (WAIT_CYCLES > 0) ? BUSY : DONE;
          cnt_q   <= (WAIT_CYCLES > 0) ? 4'd1 : 4'd0;
        end
        BUSY: if (cnt_q == 4'(WAIT_CYCLES)) begin
          state_q <= DONE;
          cnt_q   <= '0;
        end else cnt_q <= cnt_q + 4'd1;
        default: begin
          state_q <= IDLE;
          rdata_q <= rdata_d;
        end
      endcase
    end
  end
  // Storage: cleared by reset, written only by a legal store as DONE exits
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
    else if (state_q == DONE && wr_q && !err) mem_q[idx] <= wdata_q;
  end
endmodule
